// File: rtl/output_uart_pkg.sv
// rtl/output_uart_pkg.sv - shared types and constants for the output UART bridge
package output_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int         FRAME_BYTES = 3;
    localparam int         DATA_BITS   = 8;
    localparam logic [7:0] HEADER_MARK = 8'h80;

    // Header byte: marker bit set, core id zero-extended into the low bits
    function automatic logic [7:0] header_byte(input logic [6:0] core_id);
        return HEADER_MARK | {1'b0, core_id};
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 byte serializer with valid/ready input and baud counter
module uart_tx_serializer
    import output_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tdata,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic       o_idle,
    output logic       o_busy_next,
    output logic       o_uart_tx
);

    localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_uart_tx;
    logic               w_baud_done;
    logic               w_accept;
    logic               w_line;
    logic               w_ready;

    assign w_baud_done = (r_baud_cnt == CNT_LAST);
    assign w_accept    = i_tvalid && w_ready;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a new byte may chain straight from the last stop cycle, giving back-to-back bytes
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_tvalid) w_state_next = ST_START;
            ST_START: if (w_baud_done) w_state_next = ST_DATA;
            ST_DATA:  if (w_baud_done && (r_bit_idx == 3'(DATA_BITS - 1))) w_state_next = ST_STOP;
            ST_STOP:  if (w_baud_done) w_state_next = i_tvalid ? ST_START : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: line level per state and readiness to take the next byte
    always_comb begin
        w_line  = 1'b1;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_line  = 1'b1;
                w_ready = 1'b1;
            end
            ST_START: w_line = 1'b0;
            ST_DATA:  w_line = r_shift[r_bit_idx];
            ST_STOP: begin
                w_line  = 1'b1;
                w_ready = w_baud_done;
            end
            default: w_line = 1'b1;
        endcase
    end

    // Baud counter, bit index, shift register and registered line driver
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_uart_tx  <= 1'b1;
        end else begin
            if ((r_state == ST_IDLE) || w_baud_done) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + CNT_ONE;
            end
            if (r_state != ST_DATA) begin
                r_bit_idx <= '0;
            end else if (w_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_accept) begin
                r_shift <= i_tdata;
            end
            r_uart_tx <= w_line;
        end
    end

    assign o_tready    = w_ready;
    assign o_idle      = (r_state == ST_IDLE);
    assign o_busy_next = (w_state_next != ST_IDLE);
    assign o_uart_tx   = r_uart_tx;

endmodule

// File: rtl/output_uart_bridge.sv
// rtl/output_uart_bridge.sv - buffers core output events and sends each as a 3-byte UART frame
module output_uart_bridge
    import output_uart_pkg::*;
#(
    parameter  int NUM_CORES    = 16,
    parameter  int FIFO_DEPTH   = 16,
    parameter  int CLKS_PER_BIT = 434,
    localparam int ID_W         = $clog2(NUM_CORES)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_enable,
    input  logic [ID_W-1:0] in_core_id,
    input  logic [15:0]     in_data_val,
    output logic            uart_tx,
    output logic            tx_busy,
    output logic            overflow,
    output logic [7:0]      drop_count
);

    localparam int         ENTRY_W = ID_W + 16;
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [AW:0]        w_wr_next;
    logic [AW:0]        w_rd_next;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [ID_W-1:0]    w_head_id;
    logic [15:0]        w_head_data;

    logic               r_in_frame;
    logic [1:0]         r_byte_idx;
    logic [15:0]        r_shadow;
    logic               r_tx_busy;
    logic               r_overflow;
    logic [7:0]         r_drop_count;

    logic [7:0]         w_tdata;
    logic               w_tvalid;
    logic               w_tready;
    logic               w_accept;
    logic               w_ser_idle;
    logic               w_ser_busy_next;
    logic               w_ser_tx;

    assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_push      = in_enable && !w_full;
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_head_id   = w_head[ENTRY_W-1:16];
    assign w_head_data = w_head[15:0];

    // A new frame only starts from an idle serializer, which gives the one-cycle gap between frames
    assign w_tvalid = r_in_frame || (!w_empty && w_ser_idle);
    assign w_accept = w_tvalid && w_tready;
    assign w_pop    = w_accept && !r_in_frame;

    // Byte source: header straight from the FIFO head on pop, then the two data bytes from the shadow
    always_comb begin
        w_tdata = header_byte(7'(w_head_id));
        if (r_in_frame) begin
            w_tdata = (r_byte_idx == 2'd1) ? r_shadow[15:8] : r_shadow[7:0];
        end
    end

    assign w_wr_next = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_rd_next = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    // Event storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_core_id, in_data_val};
        end
    end

    // FIFO pointers; full is judged before this edge, so a push into a full FIFO drops even when popping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
        end
    end

    // Frame sequencing: capture the popped entry and walk through the remaining data bytes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_frame <= 1'b0;
            r_byte_idx <= '0;
            r_shadow   <= '0;
        end else if (w_pop) begin
            r_in_frame <= 1'b1;
            r_byte_idx <= 2'd1;
            r_shadow   <= w_head_data;
        end else if (w_accept) begin
            if (r_byte_idx == 2'(FRAME_BYTES - 1)) begin
                r_in_frame <= 1'b0;
                r_byte_idx <= '0;
            end else begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    // Drop accounting: sticky flag and saturating counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (in_enable && w_full) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // Busy flag registered from the post-edge serializer state and FIFO occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_busy <= 1'b0;
        end else begin
            r_tx_busy <= w_ser_busy_next || (w_wr_next != w_rd_next);
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .i_clk       (clk),
        .i_rst_n     (reset_n),
        .i_tdata     (w_tdata),
        .i_tvalid    (w_tvalid),
        .o_tready    (w_tready),
        .o_idle      (w_ser_idle),
        .o_busy_next (w_ser_busy_next),
        .o_uart_tx   (w_ser_tx)
    );

    assign uart_tx    = w_ser_tx;
    assign tx_busy    = r_tx_busy;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_output_uart_bridge.sv
// tb/tb_output_uart_bridge.sv - self-checking bench for output_uart_bridge
module tb_output_uart_bridge;

    localparam int NC        = 16;
    localparam int FD        = 4;
    localparam int CPB       = 4;
    localparam int IDW       = 4;
    localparam int FRAME_CYC = 30 * CPB;

    logic           clk         = 1'b0;
    logic           reset_n     = 1'b0;
    logic           in_enable   = 1'b0;
    logic [IDW-1:0] in_core_id  = '0;
    logic [15:0]    in_data_val = '0;
    logic           uart_tx;
    logic           tx_busy;
    logic           overflow;
    logic [7:0]     drop_count;

    int tests = 0;
    int fails = 0;

    output_uart_bridge #(
        .NUM_CORES   (NC),
        .FIFO_DEPTH  (FD),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_enable  (in_enable),
        .in_core_id (in_core_id),
        .in_data_val(in_data_val),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    data;
    } ev_t;

    ev_t m_q[$];
    ev_t m_frame;
    bit  m_has_frame = 0;
    int  m_age       = 0;
    bit  m_ovf       = 0;
    int  m_drops     = 0;
    bit  m_tx        = 1;
    bit  m_busy      = 0;

    // Line level at cycle k of a frame: 3 bytes of (start, 8 data LSB first, stop), CPB cycles per bit
    function automatic logic frame_bit(input ev_t ev, input int k);
        logic [7:0] b;
        int         byte_n;
        int         pos;
        byte_n = k / (10 * CPB);
        pos    = (k % (10 * CPB)) / CPB;
        case (byte_n)
            0:       b = 8'h80 | 8'(ev.id);
            1:       b = ev.data[15:8];
            default: b = ev.data[7:0];
        endcase
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        bit idle_before;
        bit was_full;
        if (!reset_n) begin
            m_q.delete();
            m_has_frame = 0;
            m_age       = 0;
            m_ovf       = 0;
            m_drops     = 0;
            m_tx        = 1;
            m_busy      = 0;
        end else begin
            idle_before = !(m_has_frame && m_age < FRAME_CYC);
            was_full    = (m_q.size() == FD);
            if (m_has_frame && m_age <= FRAME_CYC) m_age++;
            if (idle_before && m_q.size() > 0) begin
                m_frame     = m_q.pop_front();
                m_has_frame = 1;
                m_age       = 0;
            end
            if (in_enable) begin
                if (!was_full) begin
                    m_q.push_back(ev_t'({in_core_id, in_data_val}));
                end else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_tx   = (m_has_frame && m_age >= 1 && m_age <= FRAME_CYC) ? frame_bit(m_frame, m_age - 1) : 1'b1;
            m_busy = (m_has_frame && m_age < FRAME_CYC) || (m_q.size() > 0);
        end
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            check("uart_tx", {31'b0, uart_tx}, {31'b0, m_tx});
            check("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy});
            check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            check("drop_count", {24'b0, drop_count}, m_drops);
        end
    end

    // ---------------- independent UART receiver ----------------
    logic [7:0] dec_q[$];
    bit         d_act  = 0;
    int         d_cnt  = 0;
    logic [7:0] d_byte = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            d_act = 0;
        end else if (!d_act) begin
            if (uart_tx === 1'b0) begin
                d_act = 1;
                d_cnt = 0;
            end
        end else begin
            d_cnt++;
            if (d_cnt == 9 * CPB + 1) begin
                check("stop_bit", {31'b0, uart_tx}, 32'd1);
                dec_q.push_back(d_byte);
                d_act = 0;
            end else if (d_cnt > CPB && ((d_cnt - CPB - 1) % CPB) == 0) begin
                d_byte[(d_cnt - CPB - 1) / CPB] = uart_tx;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, dec_q.size(), exp.size());
        if (dec_q.size() >= exp.size()) begin
            for (int i = 0; i < exp.size(); i++) begin
                check($sformatf("%s_b%0d", name, i), {24'b0, dec_q[i]}, {24'b0, exp[i]});
            end
        end
    endtask

    logic [7:0] exp_b[$];
    logic [15:0] t2_data[5] = '{16'hA5A5, 16'h0001, 16'hFF00, 16'h8000, 16'h00FF};
    logic [15:0] t3_data[7] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_drop_count", {24'b0, drop_count}, 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1;
        repeat (2) @(negedge clk);

        // T1: single event, latency and frame content
        dec_q.delete();
        in_enable = 1'b1; in_core_id = 4'd3; in_data_val = 16'h1234;
        @(negedge clk);
        in_enable = 1'b0;
        check("t1_busy_after_strobe", {31'b0, tx_busy}, 32'd1);
        @(negedge clk);
        check("t1_line_high_n1", {31'b0, uart_tx}, 32'd1);
        @(negedge clk);
        check("t1_start_bit_n2", {31'b0, uart_tx}, 32'd0);
        repeat (118) @(negedge clk);
        check("t1_busy_n120", {31'b0, tx_busy}, 32'd1);
        @(negedge clk);
        check("t1_busy_n121", {31'b0, tx_busy}, 32'd0);
        repeat (4) @(negedge clk);
        exp_b = '{8'h83, 8'h12, 8'h34};
        check_bytes("t1", exp_b);

        // T2: five back-to-back events, all fit (4 entries + shadow)
        dec_q.delete();
        for (int i = 0; i < 5; i++) begin
            in_enable = 1'b1; in_core_id = IDW'(i); in_data_val = t2_data[i];
            @(negedge clk);
        end
        in_enable = 1'b0;
        wait_idle("t2_drain", 1000);
        exp_b = '{8'h80, 8'hA5, 8'hA5, 8'h81, 8'h00, 8'h01, 8'h82, 8'hFF, 8'h00,
                  8'h83, 8'h80, 8'h00, 8'h84, 8'h00, 8'hFF};
        check_bytes("t2", exp_b);
        check("t2_overflow", {31'b0, overflow}, 32'd0);

        // T3: seven back-to-back events, last two dropped
        dec_q.delete();
        for (int i = 0; i < 7; i++) begin
            in_enable = 1'b1; in_core_id = IDW'(8 + i); in_data_val = t3_data[i];
            @(negedge clk);
        end
        in_enable = 1'b0;
        check("t3_overflow", {31'b0, overflow}, 32'd1);
        check("t3_drop_count", {24'b0, drop_count}, 32'd2);

        // T4: 300 more strobes into a full FIFO, counter saturates
        for (int i = 0; i < 300; i++) begin
            in_enable = 1'b1; in_core_id = 4'd15; in_data_val = 16'hFFFF;
            @(negedge clk);
        end
        in_enable = 1'b0;
        check("t4_drop_sat", {24'b0, drop_count}, 32'd255);
        check("t4_overflow", {31'b0, overflow}, 32'd1);
        wait_idle("t4_drain", 3000);
        exp_b = '{8'h88, 8'h01, 8'h02, 8'h89, 8'h03, 8'h04, 8'h8A, 8'h05, 8'h06,
                  8'h8B, 8'h07, 8'h08, 8'h8C, 8'h09, 8'h0A};
        check("t4_frame_multiple", dec_q.size() % 3, 32'd0);
        if (dec_q.size() > 15) begin
            while (dec_q.size() > 15) void'(dec_q.pop_back());
        end
        check_bytes("t3", exp_b);

        // T5: reset during data bit 3 of B1 (0x12 -> bit 3 is 0)
        dec_q.delete();
        in_enable = 1'b1; in_core_id = 4'd2; in_data_val = 16'h1234;
        @(negedge clk);
        in_enable = 1'b0;
        repeat (59) @(negedge clk);
        check("t5_bit3_level", {31'b0, uart_tx}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("t5_rst_tx_busy", {31'b0, tx_busy}, 32'd0);
        check("t5_rst_overflow", {31'b0, overflow}, 32'd0);
        check("t5_rst_drop_count", {24'b0, drop_count}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        dec_q.delete();
        @(negedge clk);
        in_enable = 1'b1; in_core_id = 4'd6; in_data_val = 16'hBEEF;
        @(negedge clk);
        in_enable = 1'b0;
        wait_idle("t5_drain", 400);
        exp_b = '{8'h86, 8'hBE, 8'hEF};
        check_bytes("t5", exp_b);

        // T6: strobe on the edge where the last FIFO entry is popped
        dec_q.delete();
        in_enable = 1'b1; in_core_id = 4'd1; in_data_val = 16'h5A5A;
        @(negedge clk);
        in_core_id = 4'd9; in_data_val = 16'hC3C3;
        @(negedge clk);
        in_enable = 1'b0;
        check("t6_no_drop", {24'b0, drop_count}, 32'd0);
        wait_idle("t6_drain", 600);
        exp_b = '{8'h81, 8'h5A, 8'h5A, 8'h89, 8'hC3, 8'hC3};
        check_bytes("t6", exp_b);
        check("t6_overflow", {31'b0, overflow}, 32'd0);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
